// File: rtl/csa_seq_pkg.sv
// Shared types and helpers for the carry-save accumulation sequencer.
// Lane count and the per-beat lane-limit function live here for reuse by the top.
package csa_seq_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCUM   = 2'd1,
        RESOLVE = 2'd2,
        OUT     = 2'd3
    } state_t;

    localparam int LANES = 3;

    function automatic int unsigned min_lanes(input int unsigned remaining);
        return (remaining < LANES) ? remaining : LANES;
    endfunction

endpackage

// File: rtl/csa_6to3.sv
// 6:3 carry-save compressor: per bit column, a population count of the N inputs
// is split into sum (weight 1), middle (weight 2) and carry (weight 4) vectors.
module csa_6to3 #(
    parameter int K = 32,
    parameter int N = 6
) (
    input  logic [N*K-1:0] in_flat,
    output logic [K-1:0]   c,
    output logic [K-1:0]   o,
    output logic [K-1:0]   s
);

    // Column counts fit in 3 bits because N never exceeds 7.
    logic [K-1:0] col_b0;
    logic [K-1:0] col_b1;
    logic [K-1:0] col_b2;

    always_comb begin
        logic [2:0] cnt;
        cnt    = '0;
        col_b0 = '0;
        col_b1 = '0;
        col_b2 = '0;
        for (int i = 0; i < K; i++) begin
            cnt = '0;
            for (int j = 0; j < N; j++) begin
                cnt = cnt + {2'b00, in_flat[j*K+i]};
            end
            col_b0[i] = cnt[0];
            col_b1[i] = cnt[1];
            col_b2[i] = cnt[2];
        end
    end

    // Higher-weight vectors are pre-shifted; bits shifted past the top are dropped (mod 2^K).
    assign s = col_b0;
    assign o = {col_b1[K-2:0], 1'b0};
    assign c = {col_b2[K-3:0], 2'b00};

endmodule

// File: rtl/csa_accum_seq.sv
// Streaming multi-operand accumulator: up to three operands per beat are folded
// into a redundant (c,o,s) state, then resolved with one carry-propagate add.
module csa_accum_seq
    import csa_seq_pkg::*;
#(
    parameter  int K       = 32,
    parameter  int MAX_OPS = 64,
    localparam int W       = K + $clog2(MAX_OPS),
    localparam int CNT_W   = $clog2(MAX_OPS + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [CNT_W-1:0] num_ops,
    output logic             busy,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3*K-1:0]   in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_sum
);

    state_t           state;
    logic [W-1:0]     c_q, o_q, s_q;
    logic [W-1:0]     c_d, o_d, s_d;
    logic [CNT_W-1:0] remaining;
    logic [CNT_W-1:0] start_cnt;
    logic [1:0]       n_lanes;
    logic [K-1:0]     lane0, lane1, lane2;
    logic [6*W-1:0]   csa_in;

    // Control outputs come straight from the state register.
    assign busy      = (state != IDLE);
    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == OUT);

    assign start_cnt = (num_ops > CNT_W'(MAX_OPS)) ? CNT_W'(MAX_OPS) : num_ops;
    assign n_lanes   = 2'(min_lanes(32'(remaining)));

    // Lanes beyond the operands still owed by this job contribute nothing.
    assign lane0 = (n_lanes > 2'd0) ? in_data[K-1:0]     : '0;
    assign lane1 = (n_lanes > 2'd1) ? in_data[2*K-1:K]   : '0;
    assign lane2 = (n_lanes > 2'd2) ? in_data[3*K-1:2*K] : '0;

    assign csa_in = {W'(lane2), W'(lane1), W'(lane0), c_q, o_q, s_q};

    csa_6to3 #(
        .K (W),
        .N (6)
    ) u_csa (
        .in_flat (csa_in),
        .c       (c_d),
        .o       (o_d),
        .s       (s_d)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            c_q       <= '0;
            o_q       <= '0;
            s_q       <= '0;
            remaining <= '0;
            out_sum   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        c_q       <= '0;
                        o_q       <= '0;
                        s_q       <= '0;
                        remaining <= start_cnt;
                        state     <= (start_cnt == '0) ? RESOLVE : ACCUM;
                    end
                end
                ACCUM: begin
                    if (in_valid) begin
                        c_q       <= c_d;
                        o_q       <= o_d;
                        s_q       <= s_d;
                        remaining <= remaining - CNT_W'(n_lanes);
                        if (remaining <= CNT_W'(LANES)) begin
                            state <= RESOLVE;
                        end
                    end
                end
                RESOLVE: begin
                    out_sum <= c_q + o_q + s_q;
                    state   <= OUT;
                end
                OUT: begin
                    if (out_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_csa_accum_seq.sv
// Directed bench for csa_accum_seq at K=8, MAX_OPS=8 (W=11): hand-computed sums,
// latency, lane masking, input gaps, result backpressure and mid-job reset.
module tb_csa_accum_seq;

    localparam int K       = 8;
    localparam int MAX_OPS = 8;
    localparam int W       = 11;
    localparam int CNT_W   = 4;

    logic             clk;
    logic             rst;
    logic             start;
    logic [CNT_W-1:0] num_ops;
    logic             busy;
    logic             in_valid;
    logic             in_ready;
    logic [3*K-1:0]   in_data;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_sum;

    int tests_run;
    int tests_failed;

    csa_accum_seq #(
        .K       (K),
        .MAX_OPS (MAX_OPS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .start     (start),
        .num_ops   (num_ops),
        .busy      (busy),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp);
        end
    endtask

    // All drivers are entered and left on a falling edge.
    task automatic start_job(input int n);
        start   = 1'b1;
        num_ops = CNT_W'(n);
        @(negedge clk);
        start   = 1'b0;
    endtask

    task automatic send_beat(input logic [7:0] l0, input logic [7:0] l1, input logic [7:0] l2);
        in_valid = 1'b1;
        in_data  = {l2, l1, l0};
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic take_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst       = 1'b1;
        start     = 1'b0;
        num_ops   = '0;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        rst = 1'b0;
        @(negedge clk);

        // Three operands in one beat.
        start_job(3);
        check("j1_in_ready", in_ready, 1);
        check("j1_busy", busy, 1);
        send_beat(8'd5, 8'd7, 8'd9);
        check("j1_resolve_in_ready", in_ready, 0);
        check("j1_resolve_out_valid", out_valid, 0);
        @(negedge clk);
        check("j1_out_valid", out_valid, 1);
        check("j1_sum", out_sum, 21);
        take_out();
        check("j1_idle_busy", busy, 0);
        check("j1_idle_out_valid", out_valid, 0);

        // Eight saturated operands; the ninth lane must be masked.
        start_job(8);
        send_beat(8'hFF, 8'hFF, 8'hFF);
        send_beat(8'hFF, 8'hFF, 8'hFF);
        check("j2_in_ready_mid", in_ready, 1);
        send_beat(8'hFF, 8'hFF, 8'hFF);
        check("j2_in_ready_after", in_ready, 0);
        @(negedge clk);
        check("j2_out_valid", out_valid, 1);
        check("j2_sum", out_sum, 2040);
        take_out();

        // Single operand: lanes 1 and 2 ignored.
        start_job(1);
        send_beat(8'd200, 8'd255, 8'd255);
        check("j3_out_valid_early", out_valid, 0);
        @(negedge clk);
        check("j3_sum", out_sum, 200);
        take_out();

        // Zero operands: straight to RESOLVE.
        start_job(0);
        check("j4_in_ready", in_ready, 0);
        check("j4_out_valid_early", out_valid, 0);
        @(negedge clk);
        check("j4_out_valid", out_valid, 1);
        check("j4_sum", out_sum, 0);
        take_out();

        // Gaps between beats; only handshaked data counts.
        start_job(4);
        send_beat(8'd1, 8'd2, 8'd3);
        in_data = {8'd50, 8'd60, 8'd70};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            check("j5_gap_in_ready", in_ready, 1);
        end
        send_beat(8'd10, 8'd99, 8'd77);
        check("j5_in_ready_after", in_ready, 0);
        @(negedge clk);
        check("j5_sum", out_sum, 16);
        take_out();

        // Result backpressure with start pulsed while OUT.
        start_job(3);
        send_beat(8'd100, 8'd50, 8'd25);
        @(negedge clk);
        start   = 1'b1;
        num_ops = 4'd5;
        for (int i = 0; i < 5; i++) begin
            check("bp_out_valid", out_valid, 1);
            check("bp_sum", out_sum, 175);
            check("bp_in_ready", in_ready, 0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        start     = 1'b0;
        check("bp_idle_busy", busy, 0);
        check("bp_idle_out_valid", out_valid, 0);
        check("bp_sum_hold", out_sum, 175);

        // Mid-job asynchronous reset, then a clean job.
        start_job(6);
        send_beat(8'd1, 8'd2, 8'd3);
        #2 rst = 1'b1;
        #1;
        check("ar_busy", busy, 0);
        check("ar_out_valid", out_valid, 0);
        check("ar_in_ready", in_ready, 0);
        check("ar_out_sum", out_sum, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        start_job(2);
        send_beat(8'd4, 8'd6, 8'd200);
        check("ar_in_ready_after", in_ready, 0);
        begin
            int k;
            k = 0;
            while (!out_valid && k < 20) begin
                @(negedge clk);
                k++;
            end
        end
        check("ar_out_valid", out_valid, 1);
        check("ar_sum", out_sum, 10);
        take_out();
        check("ar_idle_busy", busy, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/csa_accum_seq.md
Name: csa_accum_seq

Overview:
- Sequences a streaming multi-operand accumulation over a 6:3 carry-save compressor.
- Each accepted beat carries up to 3 K-bit operands. Per beat, the block compresses the 3-vector redundant state (c,o,s) plus the 3 new operands back into (c,o,s).
- After the last beat, one carry-propagate resolve cycle produces a single W-bit sum.
- Used ahead of NTT/modular-reduction stages that need wide multi-operand sums without per-operand carry chains.

Parameters:
- K, 32, operand bit-width.
- MAX_OPS, 64, maximum operands per job (>=1).
- W, K+$clog2(MAX_OPS), accumulator width (derived; do not override).
- CNT_W, $clog2(MAX_OPS+1), width of the operand counter (derived).

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  reset, asynchronous, active-high.
- start  input  1  job start pulse; sampled only in IDLE.
- num_ops  input  CNT_W  operand count for the job; sampled with start.
- busy  output  1  high in every state except IDLE.
- in_valid  input  1  operand beat valid.
- in_ready  output  1  high only in ACCUM.
- in_data  input  3*K  lane0=[K-1:0], lane1=[2K-1:K], lane2=[3K-1:2K].
- out_valid  output  1  result valid; high only in OUT.
- out_ready  input  1  result accept.
- out_sum  output  W  result, sum of operands mod 2^W.

Behaviour:
- Reset: state=IDLE; c/o/s regs, out_sum, remaining counter all 0; busy=0, in_ready=0, out_valid=0. Reset takes effect asynchronously from any state, including mid-job. No residue survives reset.
- States: IDLE, ACCUM, RESOLVE, OUT. All control outputs are decoded from state only (registered, no combinational input-to-output paths).
- IDLE:
  - start=1 clears c/o/s to 0 and loads remaining=min(num_ops,MAX_OPS).
  - If that value is 0, next state is RESOLVE, giving out_sum=0. Otherwise next state is ACCUM.
- start is ignored in every non-IDLE state.
- ACCUM, on in_valid&&in_ready:
  - Let n=min(3,remaining). Lanes with index >=n are forced to 0 regardless of in_data.
  - Operands are zero-extended to W bits.
  - {c,o,s} <= compress6to3(c,o,s,lane0,lane1,lane2) at width W.
  - remaining -= n.
  - If remaining<=3 before the update, next state is RESOLVE.
- ACCUM with no handshake: state and registers hold.
- Job beat count is ceil(num_ops/3).
- RESOLVE (exactly 1 cycle): out_sum <= (c+o+s) mod 2^W; next state OUT.
- OUT:
  - out_valid=1; out_sum is stable until out_valid&&out_ready.
  - On that handshake, next state is IDLE.
  - A start in the same cycle as the handshake is ignored.
- Latency: for a last beat accepted at edge n, RESOLVE is the state during cycle n+1 and out_valid=1 from cycle n+2. A back-to-back job can start at the earliest one cycle after the out handshake.
- Arithmetic:
  - Compressor outputs are weighted s*1, o*2, c*4 (o and c are pre-shifted, top bits truncated). All vectors are mod 2^W.
  - W guarantees no overflow for MAX_OPS operands of 2^K-1.
- out_sum keeps its last value through IDLE; it is meaningful only while out_valid=1.

Decomposition:
- Package csa_seq_pkg holds:
  - the state enum (IDLE, ACCUM, RESOLVE, OUT);
  - localparam LANES=3;
  - a function min_lanes(remaining) returning min(LANES,remaining).
- Sub-module: instantiate the existing csa_6to3 compressor with K=W, N=6. Inputs are the registered c,o,s and the three masked, zero-extended lanes. Outputs feed the c/o/s registers.
- Counter, FSM, and the resolve adder are in csa_accum_seq.

Test Plan (K=8, MAX_OPS=8, W=11):
- start num_ops=3, one beat {5,7,9} -> out_valid two cycles after the beat, out_sum=21; then IDLE after out_ready.
- num_ops=8, all lanes 0xFF on 3 beats (3rd beat lane2 also 0xFF) -> only 8 operands counted; out_sum=2040 (0x7F8); in_ready low after the 3rd beat.
- num_ops=1, in_data lanes {200,255,255} -> out_sum=200. num_ops=0 -> no in_ready; out_valid 2 cycles after start with out_sum=0.
- num_ops=4, in_valid with gaps (1,0,0,1) and beats {1,2,3},{10,x,x} -> only handshaked beats count; out_sum=16.
- Result backpressure: out_ready held 0 for 5 cycles with start pulsed -> out_valid and out_sum stable, in_ready=0, start ignored; out_ready=1 -> IDLE next cycle.
- num_ops=6, one beat accepted, then rst for 1 cycle -> busy=0 and out_valid=0 immediately. New job num_ops=2 {4,6} -> out_sum=10, with no residue from the aborted job.
